// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, op codes, 5-bit ALU select
// encodings and the layout of the registered ID/EX slot.
package alu_pkg;

   localparam int XLEN  = 32;
   localparam int RADDR = 5;

   // Decoded 4-bit operation codes; 8-15 are illegal.
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_SEQ = 4'd2,
      OP_SNE = 4'd3,
      OP_SLT = 4'd4,
      OP_SGT = 4'd5,
      OP_SLE = 4'd6,
      OP_SGE = 4'd7
   } alu_op_e;

   // ALU select word {sel4,sel3,sel2,sel1,sel0}; the ALU decoder uses the same constants.
   typedef logic [4:0] alu_ctrl_t;

   localparam alu_ctrl_t CTRL_ADD = 5'b00000;
   localparam alu_ctrl_t CTRL_SUB = 5'b11000;
   localparam alu_ctrl_t CTRL_SEQ = 5'b10000;
   localparam alu_ctrl_t CTRL_SNE = 5'b10001;
   localparam alu_ctrl_t CTRL_SLT = 5'b10010;
   localparam alu_ctrl_t CTRL_SGT = 5'b10011;
   localparam alu_ctrl_t CTRL_SLE = 5'b10100;
   localparam alu_ctrl_t CTRL_SGE = 5'b10110;

   // Everything the EX slot remembers about one instruction. An all-zero
   // value is a bubble: invalid, register 0 sources, ADD select.
   typedef struct packed {
      logic             valid;
      logic [RADDR-1:0] rs1;
      logic [RADDR-1:0] rs2;
      logic [RADDR-1:0] rd;
      logic [XLEN-1:0]  rs1_val;
      logic [XLEN-1:0]  rs2_val;
      logic [XLEN-1:0]  imm;
      logic             use_imm;
      logic             is_load;
      alu_ctrl_t        ctrl;
      logic             illegal;
   } ex_slot_t;

   // Only codes 0-7 name a real ALU operation.
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op[3] == 1'b0);
   endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of the decode-side inputs, writeback candidates and EX-side
// outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if;
   import alu_pkg::*;

   // decode slot
   logic             id_valid;
   logic [3:0]       id_op;
   logic [RADDR-1:0] id_rs1;
   logic [RADDR-1:0] id_rs2;
   logic [RADDR-1:0] id_rd;
   logic [XLEN-1:0]  id_rs1_val;
   logic [XLEN-1:0]  id_rs2_val;
   logic [XLEN-1:0]  id_imm;
   logic             id_use_imm;
   logic             id_is_load;

   // pipeline control
   logic             stall_in;
   logic             flush;

   // writeback candidates
   logic             exm_we;
   logic [RADDR-1:0] exm_rd;
   logic [XLEN-1:0]  exm_result;
   logic             mwb_we;
   logic [RADDR-1:0] mwb_rd;
   logic [XLEN-1:0]  mwb_result;

   // EX slot towards the ALU
   logic             ex_valid;
   logic [XLEN-1:0]  ex_in1;
   logic [XLEN-1:0]  ex_in2;
   logic [4:0]       ex_ctrl;
   logic [RADDR-1:0] ex_rd;
   logic             ex_is_load;
   logic             ex_illegal;
   logic             hazard_stall;

   modport slave (
      input  id_valid, id_op, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
             id_imm, id_use_imm, id_is_load, stall_in, flush,
             exm_we, exm_rd, exm_result, mwb_we, mwb_rd, mwb_result,
      output ex_valid, ex_in1, ex_in2, ex_ctrl, ex_rd, ex_is_load, ex_illegal,
             hazard_stall
   );

   modport master (
      output id_valid, id_op, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
             id_imm, id_use_imm, id_is_load, stall_in, flush,
             exm_we, exm_rd, exm_result, mwb_we, mwb_rd, mwb_result,
      input  ex_valid, ex_in1, ex_in2, ex_ctrl, ex_rd, ex_is_load, ex_illegal,
             hazard_stall
   );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight writeback for a
// source register, with register 0 always reading as zero.
module operand_fwd_mux
   import alu_pkg::*;
(
   input  logic [RADDR-1:0] rs,
   input  logic [XLEN-1:0]  rf_val,
   input  logic             exm_we,
   input  logic [RADDR-1:0] exm_rd,
   input  logic [XLEN-1:0]  exm_result,
   input  logic             mwb_we,
   input  logic [RADDR-1:0] mwb_rd,
   input  logic [XLEN-1:0]  mwb_result,
   output logic [XLEN-1:0]  operand
);

   // Priority: r0 > EX/MEM (younger) > MEM/WB > register-file value.
   always_comb begin
      operand = rf_val;
      if (rs == '0) begin
         operand = '0;
      end else if (exm_we && (exm_rd == rs)) begin
         operand = exm_result;
      end else if (mwb_we && (mwb_rd == rs)) begin
         operand = mwb_result;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX stage feeding the ALU: registers the decoded instruction, maps the
// op to the ALU select word, forwards operands and flags load-use hazards.
module id_ex_operand_stage
   import alu_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   id_ex_operand_stage_if.slave   bus
);

   ex_slot_t         slot_reg;
   ex_slot_t         slot_next;
   ex_slot_t         id_slot;
   logic             hazard_raw;
   logic             hazard;

   logic [RADDR-1:0] src_idx [2];
   logic [XLEN-1:0]  src_rf  [2];
   logic [XLEN-1:0]  fwd_val [2];

   // Build the candidate EX slot from the decode inputs, translating op to ALU select.
   always_comb begin
      id_slot         = '0;
      id_slot.valid   = bus.id_valid;
      id_slot.rs1     = bus.id_rs1;
      id_slot.rs2     = bus.id_rs2;
      id_slot.rd      = bus.id_rd;
      id_slot.rs1_val = bus.id_rs1_val;
      id_slot.rs2_val = bus.id_rs2_val;
      id_slot.imm     = bus.id_imm;
      id_slot.use_imm = bus.id_use_imm;
      id_slot.is_load = bus.id_is_load;
      id_slot.illegal = ~op_is_legal(bus.id_op);
      case (bus.id_op)
         OP_ADD:  id_slot.ctrl = CTRL_ADD;
         OP_SUB:  id_slot.ctrl = CTRL_SUB;
         OP_SEQ:  id_slot.ctrl = CTRL_SEQ;
         OP_SNE:  id_slot.ctrl = CTRL_SNE;
         OP_SLT:  id_slot.ctrl = CTRL_SLT;
         OP_SGT:  id_slot.ctrl = CTRL_SGT;
         OP_SLE:  id_slot.ctrl = CTRL_SLE;
         OP_SGE:  id_slot.ctrl = CTRL_SGE;
         default: id_slot.ctrl = CTRL_ADD;   // illegal ops behave as ADD, flagged separately
      endcase
   end

   // Load-use check against the load sitting in EX. A flush squashes the ID
   // instruction, so there is nothing to hold in that case.
   assign hazard_raw = bus.id_valid & slot_reg.valid & slot_reg.is_load &
                       (slot_reg.rd != '0) &
                       ((slot_reg.rd == bus.id_rs1) |
                        ((slot_reg.rd == bus.id_rs2) & ~bus.id_use_imm));
   assign hazard     = hazard_raw & ~bus.flush & ~reset;

   // Next slot: flush > downstream hold > hazard bubble > capture decode.
   always_comb begin
      slot_next = slot_reg;
      if (bus.flush) begin
         slot_next = '0;
      end else if (bus.stall_in) begin
         slot_next = slot_reg;
      end else if (hazard) begin
         slot_next = '0;
      end else begin
         slot_next = id_slot;
      end
   end

   // Slot register with synchronous reset; reset overrides every other request.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_reg <= '0;
      end else begin
         slot_reg <= slot_next;
      end
   end

   assign src_idx[0] = slot_reg.rs1;
   assign src_idx[1] = slot_reg.rs2;
   assign src_rf[0]  = slot_reg.rs1_val;
   assign src_rf[1]  = slot_reg.rs2_val;

   // One forwarding mux per source operand, evaluated every cycle so that
   // writebacks arriving while the slot is held are still picked up.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         operand_fwd_mux u_mux (
            .rs         (src_idx[gi]),
            .rf_val     (src_rf[gi]),
            .exm_we     (bus.exm_we),
            .exm_rd     (bus.exm_rd),
            .exm_result (bus.exm_result),
            .mwb_we     (bus.mwb_we),
            .mwb_rd     (bus.mwb_rd),
            .mwb_result (bus.mwb_result),
            .operand    (fwd_val[gi])
         );
      end
   endgenerate

   assign bus.ex_valid     = slot_reg.valid;
   assign bus.ex_in1       = fwd_val[0];
   assign bus.ex_in2       = slot_reg.use_imm ? slot_reg.imm : fwd_val[1];
   assign bus.ex_ctrl      = slot_reg.ctrl;
   assign bus.ex_rd        = slot_reg.rd;
   assign bus.ex_is_load   = slot_reg.is_load;
   assign bus.ex_illegal   = slot_reg.illegal;
   assign bus.hazard_stall = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: the stimulus process pushes
// hand-computed expectations tagged with the cycle they are due; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_id_ex_operand_stage;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;

   id_ex_operand_stage_if bus ();

   id_ex_operand_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          at;
      bit          is_hz;
      string       name;
      logic [76:0] ex;
      logic        hz;
   } exp_t;

   exp_t sbq[$];
   bit   mon_seen_ex;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // EX view packed as {valid, in1, in2, ctrl, rd, is_load, illegal}
   function automatic logic [76:0] pk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] c, input logic [4:0] rd,
                                      input logic ld, input logic ill);
      return {v, a, b, c, rd, ld, ill};
   endfunction

   task automatic exp_ex(input int dly, input string nm, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] c, input logic [4:0] rd,
                         input logic ld, input logic ill);
      exp_t e;
      e.at = cyc + dly; e.is_hz = 1'b0; e.name = nm;
      e.ex = pk(v, a, b, c, rd, ld, ill); e.hz = 1'b0;
      sbq.push_back(e);
   endtask

   task automatic exp_bubble(input int dly, input string nm);
      exp_ex(dly, nm, 1'b0, 32'h0, 32'h0, 5'b00000, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic exp_hz(input int dly, input string nm, input logic hz);
      exp_t e;
      e.at = cyc + dly; e.is_hz = 1'b1; e.name = nm; e.ex = '0; e.hz = hz;
      sbq.push_back(e);
   endtask

   task automatic drive_id(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] imm, input logic ui,
                           input logic ld);
      bus.id_valid = v;     bus.id_op = op;
      bus.id_rs1 = rs1;     bus.id_rs2 = rs2;       bus.id_rd = rd;
      bus.id_rs1_val = v1;  bus.id_rs2_val = v2;    bus.id_imm = imm;
      bus.id_use_imm = ui;  bus.id_is_load = ld;
   endtask

   task automatic set_wb(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                         input logic mw, input logic [4:0] mr, input logic [31:0] mv);
      bus.exm_we = ew; bus.exm_rd = er; bus.exm_result = ev;
      bus.mwb_we = mw; bus.mwb_rd = mr; bus.mwb_result = mv;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due this cycle; any valid EX output
   // without a matching expectation is itself an error.
   always @(negedge clk) begin
      mon_seen_ex = 1'b0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].at == cyc) begin
            checks++;
            if (sbq[i].is_hz) begin
               if (bus.hazard_stall !== sbq[i].hz) begin
                  failures++;
                  $display("FAIL hz %s cyc=%0d got=%b exp=%b", sbq[i].name, cyc,
                           bus.hazard_stall, sbq[i].hz);
               end else begin
                  $display("ok   hz %s cyc=%0d hazard_stall=%b", sbq[i].name, cyc, bus.hazard_stall);
               end
            end else begin
               mon_seen_ex = 1'b1;
               if (pk(bus.ex_valid, bus.ex_in1, bus.ex_in2, bus.ex_ctrl, bus.ex_rd,
                      bus.ex_is_load, bus.ex_illegal) !== sbq[i].ex) begin
                  failures++;
                  $display("FAIL ex %s cyc=%0d got v=%b in1=%h in2=%h ctrl=%b rd=%0d ld=%b ill=%b exp {v,in1,in2,ctrl,rd,ld,ill}=%h",
                           sbq[i].name, cyc, bus.ex_valid, bus.ex_in1, bus.ex_in2, bus.ex_ctrl,
                           bus.ex_rd, bus.ex_is_load, bus.ex_illegal, sbq[i].ex);
               end else begin
                  $display("ok   ex %s cyc=%0d v=%b in1=%h in2=%h ctrl=%b rd=%0d", sbq[i].name, cyc,
                           bus.ex_valid, bus.ex_in1, bus.ex_in2, bus.ex_ctrl, bus.ex_rd);
               end
            end
            sbq.delete(i);
         end else if (sbq[i].at < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed %s due=%0d now=%0d", sbq[i].name, sbq[i].at, cyc);
            sbq.delete(i);
         end
      end
      if (bus.ex_valid === 1'b1 && !mon_seen_ex) begin
         checks++;
         failures++;
         $display("FAIL unexpected_valid cyc=%0d got ex_valid=1 exp none", cyc);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus.stall_in = 1'b0;
      bus.flush = 1'b0;
      set_wb(0, 0, 0, 0, 0, 0);
      // cyc0: reset held for two edges with a valid SLT presented
      drive_id(1, 4'd4, 5'd3, 5'd4, 5'd10, 32'd5, 32'd9, 32'd0, 0, 0);
      exp_bubble(1, "reset_a");
      exp_hz(1, "reset_hz", 1'b0);
      exp_bubble(2, "reset_b");
      step();
      step();
      // cyc2: release reset, SLT captured next edge
      reset = 1'b0;
      exp_hz(0, "slt_hz", 1'b0);
      exp_ex(1, "plain_slt", 1, 32'd5, 32'd9, 5'b10010, 5'd10, 0, 0);
      step();
      // cyc3: ADD rs1=3; both buses write r3 next cycle, EX/MEM wins
      drive_id(1, 4'd0, 5'd3, 5'd4, 5'd11, 32'h100, 32'h200, 32'd0, 0, 0);
      exp_ex(1, "fwd_exm_wins", 1, 32'h11, 32'h200, 5'b00000, 5'd11, 0, 0);
      step();
      // cyc4: buses target r3; same ADD again, buses switch to rd=0 next cycle
      set_wb(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
      exp_ex(1, "fwd_rd0_bus", 1, 32'h100, 32'h200, 5'b00000, 5'd11, 0, 0);
      step();
      // cyc5: buses write r0; SEQ with rs1=0 must read zero
      set_wb(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
      drive_id(1, 4'd2, 5'd0, 5'd4, 5'd12, 32'h55, 32'd7, 32'd0, 0, 0);
      exp_ex(1, "rs0_zero", 1, 32'h0, 32'd7, 5'b10000, 5'd12, 0, 0);
      step();
      // cyc6: SNE; next cycle MEM/WB feeds rs1, EX/MEM feeds rs2
      drive_id(1, 4'd3, 5'd5, 5'd6, 5'd13, 32'd1, 32'd2, 32'd0, 0, 0);
      exp_ex(1, "fwd_split", 1, 32'h55, 32'h66, 5'b10001, 5'd13, 0, 0);
      step();
      // cyc7: matching indices but write enables low next cycle
      set_wb(1, 5'd6, 32'h66, 1, 5'd5, 32'h55);
      drive_id(1, 4'd5, 5'd5, 5'd6, 5'd14, 32'd1, 32'd2, 32'd0, 0, 0);
      exp_ex(1, "no_we", 1, 32'd1, 32'd2, 5'b10011, 5'd14, 0, 0);
      step();
      // cyc8: load r7 <- [r1+4]
      set_wb(0, 5'd5, 32'h99, 0, 5'd6, 32'h88);
      drive_id(1, 4'd0, 5'd1, 5'd0, 5'd7, 32'h1000, 32'd0, 32'd4, 1, 1);
      exp_ex(1, "load_a", 1, 32'h1000, 32'd4, 5'b00000, 5'd7, 1, 0);
      step();
      // cyc9: SUB uses r7 as rs2 -> load-use stall, bubble next
      set_wb(0, 0, 0, 0, 0, 0);
      drive_id(1, 4'd1, 5'd2, 5'd7, 5'd8, 32'd10, 32'd3, 32'd0, 0, 0);
      exp_hz(0, "loaduse_hz", 1'b1);
      exp_bubble(1, "loaduse_bubble");
      step();
      // cyc10: bubble in EX, SUB goes through; load result via MEM/WB next cycle
      exp_hz(0, "loaduse_clear", 1'b0);
      exp_ex(1, "loaduse_sub", 1, 32'd10, 32'hAB, 5'b11000, 5'd8, 0, 0);
      step();
      // cyc11: second load r7
      set_wb(0, 0, 0, 1, 5'd7, 32'hAB);
      drive_id(1, 4'd0, 5'd1, 5'd0, 5'd7, 32'h1000, 32'd0, 32'd4, 1, 1);
      exp_hz(0, "nonload_hz", 1'b0);
      exp_ex(1, "load_b", 1, 32'h1000, 32'd4, 5'b00000, 5'd7, 1, 0);
      step();
      // cyc12: SUB with rs2=7 but immediate operand -> no stall
      set_wb(0, 0, 0, 0, 0, 0);
      drive_id(1, 4'd1, 5'd2, 5'd7, 5'd8, 32'd10, 32'd3, 32'd5, 1, 0);
      exp_hz(0, "imm_no_hz", 1'b0);
      exp_ex(1, "sub_imm", 1, 32'd10, 32'd5, 5'b11000, 5'd8, 0, 0);
      step();
      // cyc13: SGE r9,r4
      drive_id(1, 4'd7, 5'd9, 5'd4, 5'd12, 32'h30, 32'h40, 32'd0, 0, 0);
      exp_ex(1, "sge", 1, 32'h30, 32'h40, 5'b10110, 5'd12, 0, 0);
      step();
      // cyc14-16: stall_in held; decode changes but EX must not
      bus.stall_in = 1'b1;
      drive_id(1, 4'd0, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'd0, 0, 0);
      exp_ex(1, "hold_1", 1, 32'h30, 32'h40, 5'b10110, 5'd12, 0, 0);
      step();
      exp_ex(1, "hold_late_wb", 1, 32'h99, 32'h40, 5'b10110, 5'd12, 0, 0);
      step();
      set_wb(0, 0, 0, 1, 5'd9, 32'h99);
      exp_ex(1, "hold_3", 1, 32'h30, 32'h40, 5'b10110, 5'd12, 0, 0);
      step();
      // cyc17: release stall, load r7 <- [r1+8]
      set_wb(0, 0, 0, 0, 0, 0);
      bus.stall_in = 1'b0;
      drive_id(1, 4'd0, 5'd1, 5'd0, 5'd7, 32'h2000, 32'd0, 32'd8, 1, 1);
      exp_ex(1, "load_c", 1, 32'h2000, 32'd8, 5'b00000, 5'd7, 1, 0);
      step();
      // cyc18: SLE uses r7 as rs1 while stall_in=1: hazard raised, EX held
      bus.stall_in = 1'b1;
      drive_id(1, 4'd6, 5'd7, 5'd2, 5'd13, 32'd0, 32'h77, 32'd0, 0, 0);
      exp_hz(0, "hz_in_stall", 1'b1);
      exp_ex(1, "stall_over_hz", 1, 32'h2000, 32'd8, 5'b00000, 5'd7, 1, 0);
      step();
      // cyc19: stall released, hazard now bubbles
      bus.stall_in = 1'b0;
      exp_hz(0, "hz_after_stall", 1'b1);
      exp_bubble(1, "hz_bubble");
      step();
      // cyc20: SLE captured; load data arrives on MEM/WB next cycle
      exp_hz(0, "hz_gone", 1'b0);
      exp_ex(1, "sle_fwd", 1, 32'd5, 32'h77, 5'b10100, 5'd13, 0, 0);
      step();
      // cyc21: load r7 <- [r1+0]
      set_wb(0, 0, 0, 1, 5'd7, 32'd5);
      drive_id(1, 4'd0, 5'd1, 5'd0, 5'd7, 32'h3000, 32'd0, 32'd0, 1, 1);
      exp_ex(1, "load_d", 1, 32'h3000, 32'd0, 5'b00000, 5'd7, 1, 0);
      step();
      // cyc22: dependent SUB, flush and stall together: no hazard, bubble
      set_wb(0, 0, 0, 0, 0, 0);
      bus.flush = 1'b1;
      bus.stall_in = 1'b1;
      drive_id(1, 4'd1, 5'd7, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 0, 0);
      exp_hz(0, "flush_hz", 1'b0);
      exp_bubble(1, "flush_stall");
      step();
      // cyc23: illegal op 12
      bus.flush = 1'b0;
      bus.stall_in = 1'b0;
      drive_id(1, 4'd12, 5'd2, 5'd3, 5'd14, 32'h12, 32'h34, 32'd0, 0, 0);
      exp_hz(0, "bubble_hz", 1'b0);
      exp_ex(1, "illegal_op", 1, 32'h12, 32'h34, 5'b00000, 5'd14, 0, 1);
      step();
      // cyc24: reset during a stall clears the slot
      bus.stall_in = 1'b1;
      reset = 1'b1;
      exp_bubble(1, "reset_in_stall");
      step();
      // cyc25: idle
      reset = 1'b0;
      bus.stall_in = 1'b0;
      drive_id(0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0);
      exp_bubble(1, "idle");
      step();
      step();
      step();
      foreach (sbq[i]) begin
         checks++;
         failures++;
         $display("FAIL leftover %s due=%0d now=%0d", sbq[i].name, sbq[i].at, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
